conf_int_mul__seq_hs: RTL and testbench
=======================================

# conf_int_mul__seq_hs

Sequential, handshaked, configurable-precision signed integer multiplier. It is the responder side of the operand-pair stream that the functional benches drive. It accepts one `(a, b)` pair per transaction and computes the product with a radix-2 Booth iteration over `OP_BITWIDTH` bits. It returns the sign-extended product with back-pressure, so results can be logged in order for the C-model comparison flow.

## Interface
- `OP_BITWIDTH`, 18: significant operand bits, signed; must satisfy 2 ≤ `OP_BITWIDTH` ≤ `DATA_PATH_BITWIDTH`.
- `DATA_PATH_BITWIDTH`, 24: physical operand port width.
- `APX_BITS`, 4: operand LSBs cleared in approximate mode; must satisfy `APX_BITS` < `OP_BITWIDTH`.

Ports (reset is asynchronous, active-high):
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `a` input `DATA_PATH_BITWIDTH`: operand A.
- `b` input `DATA_PATH_BITWIDTH`: operand B.
- `acc__sel` input 1: 0 = accurate, 1 = approximate; sampled at accept.
- `in_valid` input 1: operand pair valid.
- `in_ready` output 1: block can accept a pair.
- `d` output `2*DATA_PATH_BITWIDTH`: signed product.
- `out_valid` output 1: `d` holds a new result.
- `out_ready` input 1: consumer accepts `d`.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: `in_ready`=1. On an edge with `in_valid`&&`in_ready` (accept):
  - Capture `a[OP_BITWIDTH-1:0]` and `b[OP_BITWIDTH-1:0]` as signed values. Bits above `OP_BITWIDTH-1` are ignored.
  - If `acc__sel`=1, clear the low `APX_BITS` bits of both captured operands.
  - Clear the accumulator, load the iteration counter with `OP_BITWIDTH`, and go to BUSY.
- BUSY: perform one Booth radix-2 step per cycle on the multiplier bit pair {b[i], b[i-1]}, with b[-1]=0:
  - 01: add A.
  - 10: subtract A.
  - 00 and 11: no-op.
  - Then arithmetic-shift right.
- The accumulator is 2*`OP_BITWIDTH`+1 bits wide, with no overflow possible.
- After the step that brings the counter to 0, load `d` with the exact 2*`OP_BITWIDTH`-bit signed product, sign-extended to 2*`DATA_PATH_BITWIDTH`, and go to DONE.
- DONE: `out_valid`=1 and `d` is stable. On an edge with `out_valid`&&`out_ready`, go to IDLE.
- `in_ready`=0 in BUSY and DONE. `in_valid` is ignored there, so a pair offered while busy stays pending upstream.
- `d` holds the last product after the handshake until the next DONE.
- `acc__sel` changes while BUSY have no effect on the running transaction.

## Timing
- Reset values: state=IDLE, `in_ready`=1, `out_valid`=0, `d`=0, counter=0, accumulator=0.
- Reset is asynchronous. Asserting `rst` mid-BUSY or mid-DONE immediately discards the transaction, with no partial result ever presented.
- Latency: `out_valid` rises exactly `OP_BITWIDTH` cycles after the accept edge (first visible in the cycle after edge E+`OP_BITWIDTH`).
- Throughput with `out_ready` tied high: one pair per `OP_BITWIDTH`+2 cycles. This is accept, `OP_BITWIDTH` BUSY cycles, and the DONE handshake cycle; `in_ready` returns the cycle after the output handshake.
- Back-pressure: while `out_ready`=0 the block stays in DONE indefinitely with `d` and `out_valid` constant.
- `out_valid` never drops without a handshake.
- `in_valid` asserted in the same cycle `rst` deasserts: accept occurs on the first rising edge with `rst` low.

## Structure
- Package `conf_int_mul_pkg`:
  - state enum {IDLE, BUSY, DONE};
  - `ACC_W` = 2*`OP_BITWIDTH`+1;
  - counter width = $clog2(`OP_BITWIDTH`+1);
  - Booth opcode constants.
- Sub-module `conf_int_mul_booth_r2_step`: combinational; inputs are accumulator, multiplicand, and bit pair; output is the next accumulator.
- Top: FSM, counter, operand/approximation capture, and the output register.

## Test plan
1. Reset: `rst`=1 for 30 cycles; check `in_ready`=1, `out_valid`=0, `d`=0. Then accept a=3, b=-5 (acc__sel=0): `d`=-15 after exactly 18 cycles.
2. Extremes (`OP_BITWIDTH`=18): a=b=-131072 → `d`=17179869184. Also a=-131072, b=131071 → `d`=-17179738112.
3. Upper-bit masking: a=24'hFC0003, b=24'h000007 → `d`=21.
4. Approximate mode: acc__sel=1, a=0x1F, b=0x13 → operands become 0x10 and 0x10, giving `d`=256. The same pair with acc__sel=0 gives `d`=589.
5. Back-pressure: hold `out_ready`=0 for 40 cycles after DONE. Check `d` and `out_valid` stay stable and `in_valid` pulses are not accepted. Release → exactly one handshake, then `in_ready`=1 on the next cycle.
6. Reset mid-operation: assert `rst` 7 cycles after accept → `out_valid` never rises for that pair. The next pair 2×3 returns `d`=6 with full latency. Finish with a 500-pair random stream compared against the `$signed` product.

Source files
------------

// File: rtl/conf_int_mul_pkg.sv
// Shared types and constants for the sequential Booth radix-2 multiplier.
package conf_int_mul_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    // Booth radix-2 opcodes on the multiplier bit pair {b[i], b[i-1]}
    localparam logic [1:0] BOOTH_NOP0 = 2'b00;
    localparam logic [1:0] BOOTH_ADD  = 2'b01;
    localparam logic [1:0] BOOTH_SUB  = 2'b10;
    localparam logic [1:0] BOOTH_NOP1 = 2'b11;

    function automatic int unsigned acc_w(input int unsigned op_bw);
        return 2 * op_bw + 1;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned op_bw);
        return $clog2(op_bw + 1);
    endfunction

endpackage

// File: rtl/conf_int_mul_booth_r2_step.sv
// One combinational Booth radix-2 step: add/subtract the multiplicand into the
// upper accumulator half, then arithmetic-shift the whole accumulator right.
module conf_int_mul_booth_r2_step
    import conf_int_mul_pkg::*;
#(
    parameter int unsigned OP_BITWIDTH = 18,
    localparam int unsigned ACC_W = 2 * OP_BITWIDTH + 1
) (
    input  logic [ACC_W-1:0]       acc,
    input  logic [OP_BITWIDTH-1:0] mcand,
    input  logic [1:0]             pair,
    output logic [ACC_W-1:0]       acc_next
);

    logic [OP_BITWIDTH:0] hi;
    logic [OP_BITWIDTH:0] mc_ext;
    logic [OP_BITWIDTH:0] hi_sum;

    always_comb begin
        hi     = acc[ACC_W-1:OP_BITWIDTH];
        mc_ext = {mcand[OP_BITWIDTH-1], mcand};
        case (pair)
            BOOTH_ADD: hi_sum = hi + mc_ext;
            BOOTH_SUB: hi_sum = hi - mc_ext;
            default:   hi_sum = hi;
        endcase
        // Partial sums never exceed 2^(2n-1) in magnitude, so the extra top bit absorbs them.
        acc_next = {hi_sum[OP_BITWIDTH], hi_sum, acc[OP_BITWIDTH-1:1]};
    end

endmodule

// File: rtl/conf_int_mul__seq_hs.sv
// Handshaked sequential signed multiplier: one Booth radix-2 step per cycle,
// optional approximate mode that clears operand LSBs at accept.
module conf_int_mul__seq_hs
    import conf_int_mul_pkg::*;
#(
    parameter int unsigned OP_BITWIDTH        = 18,
    parameter int unsigned DATA_PATH_BITWIDTH = 24,
    parameter int unsigned APX_BITS           = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_PATH_BITWIDTH-1:0]   a,
    input  logic [DATA_PATH_BITWIDTH-1:0]   b,
    input  logic                            acc__sel,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [2*DATA_PATH_BITWIDTH-1:0] d,
    output logic                            out_valid,
    input  logic                            out_ready
);

    localparam int unsigned ACC_W = acc_w(OP_BITWIDTH);
    localparam int unsigned CNT_W = cnt_w(OP_BITWIDTH);
    localparam int unsigned D_W   = 2 * DATA_PATH_BITWIDTH;

    state_t                   state;
    logic [CNT_W-1:0]         cnt;
    logic [ACC_W-1:0]         acc;
    logic [ACC_W-1:0]         acc_next;
    logic [OP_BITWIDTH-1:0]   mcand;
    logic [OP_BITWIDTH:0]     mplier;
    logic [OP_BITWIDTH-1:0]   apx_mask;
    logic [OP_BITWIDTH-1:0]   a_cap;
    logic [OP_BITWIDTH-1:0]   b_cap;
    logic signed [2*OP_BITWIDTH-1:0] prod;
    logic                     unused_bits;

    assign apx_mask    = '1 << APX_BITS;
    assign a_cap       = a[OP_BITWIDTH-1:0] & (acc__sel ? apx_mask : '1);
    assign b_cap       = b[OP_BITWIDTH-1:0] & (acc__sel ? apx_mask : '1);
    assign prod        = acc_next[2*OP_BITWIDTH-1:0];
    assign unused_bits = ^{a, b, acc_next};

    conf_int_mul_booth_r2_step #(
        .OP_BITWIDTH(OP_BITWIDTH)
    ) u_step (
        .acc      (acc),
        .mcand    (mcand),
        .pair     (mplier[1:0]),
        .acc_next (acc_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            d         <= '0;
            cnt       <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand    <= a_cap;
                        // Appended zero is the implicit b[-1] of the first Booth pair.
                        mplier   <= {b_cap, 1'b0};
                        acc      <= '0;
                        cnt      <= CNT_W'(OP_BITWIDTH);
                        in_ready <= 1'b0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    acc    <= acc_next;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        d         <= D_W'(prod);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conf_int_mul__seq_hs.sv
// Scoreboard bench for conf_int_mul__seq_hs: directed vectors plus a random stream.
module tb_conf_int_mul__seq_hs;

    localparam int OPW = 18;
    localparam int DW  = 24;
    localparam int APX = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [DW-1:0]     a;
    logic [DW-1:0]     b;
    logic              acc__sel;
    logic              in_valid;
    logic              in_ready;
    logic [2*DW-1:0]   d;
    logic              out_valid;
    logic              out_ready;

    int checks   = 0;
    int failures = 0;
    logic signed [2*DW-1:0] exp_q[$];
    bit rnd_done = 1'b0;

    always #5 clk = ~clk;

    conf_int_mul__seq_hs #(
        .OP_BITWIDTH       (OPW),
        .DATA_PATH_BITWIDTH(DW),
        .APX_BITS          (APX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .acc__sel  (acc__sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .d         (d),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic signed [2*DW-1:0] model(input logic [DW-1:0] x,
                                                     input logic [DW-1:0] y,
                                                     input logic sel);
        logic signed [OPW-1:0]  sx, sy;
        logic signed [2*DW-1:0] ex, ey;
        sx = x[OPW-1:0];
        sy = y[OPW-1:0];
        if (sel) begin
            sx[APX-1:0] = '0;
            sy[APX-1:0] = '0;
        end
        ex = sx;
        ey = sy;
        return ex * ey;
    endfunction

    // Monitor: a handshake seen here completes on the next rising edge.
    always @(negedge clk) begin
        #1;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output actual=%0d required=none", $signed(d));
            end else begin
                check("product", $signed(d), exp_q.pop_front());
            end
        end
    end

    task automatic send(input logic [DW-1:0] ta, input logic [DW-1:0] tb,
                        input logic sel, input logic signed [2*DW-1:0] e,
                        input bit expect_out);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", in_ready, 1);
            return;
        end
        a        = ta;
        b        = tb;
        acc__sel = sel;
        in_valid = 1'b1;
        if (expect_out) exp_q.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic latency_check(input string name);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!out_valid && n < 100);
        check(name, n, OPW);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    initial begin
        logic [2*DW-1:0] held_d;
        bit              stable;
        bit              seen;
        int              n;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; acc__sel = 1'b0;

        // 1. reset values and first product latency
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_d", $signed(d), 0);
        rst = 1'b0;
        send(24'd3, 24'hFFFFFB, 1'b0, -48'sd15, 1'b1);
        latency_check("latency_first");
        drain();

        // 2-4. extremes, upper-bit masking, approximate mode
        send(24'hFE0000, 24'hFE0000, 1'b0, 48'sd17179869184, 1'b1);
        send(24'hFE0000, 24'h01FFFF, 1'b0, -48'sd17179738112, 1'b1);
        send(24'hFC0003, 24'h000007, 1'b0, 48'sd21, 1'b1);
        send(24'h00001F, 24'h000013, 1'b1, 48'sd256, 1'b1);
        send(24'h00001F, 24'h000013, 1'b0, 48'sd589, 1'b1);
        drain();

        // 5. back-pressure
        @(negedge clk);
        out_ready = 1'b0;
        send(24'd5, 24'd6, 1'b0, 48'sd30, 1'b1);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("bp_out_valid", out_valid, 1);
        held_d = d;
        stable = 1'b1;
        a = 24'd9; b = 24'd9;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            in_valid = i[0];
            if (!out_valid || d !== held_d || in_ready) stable = 1'b0;
        end
        check("bp_stable", stable, 1);
        check("bp_d_value", $signed(held_d), 30);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_out_valid", out_valid, 0);
        check("bp_release_in_ready", in_ready, 1);
        drain();

        // 6. reset mid-operation discards the transaction
        send(24'd7, 24'd7, 1'b0, 48'sd49, 1'b0);
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        repeat (2) @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("midrst_no_output", seen, 0);
        send(24'd2, 24'd3, 1'b0, 48'sd6, 1'b1);
        latency_check("latency_after_rst");
        drain();

        // random stream with random back-pressure
        fork
            begin
                while (!rnd_done) begin
                    @(negedge clk);
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join_none
        for (int i = 0; i < 500; i++) begin
            logic [DW-1:0] ra, rb;
            logic          rs;
            ra = DW'($urandom);
            rb = DW'($urandom);
            rs = 1'($urandom_range(0, 1));
            send(ra, rb, rs, model(ra, rb, rs), 1'b1);
        end
        rnd_done = 1'b1;
        @(negedge clk);
        out_ready = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
